// File: rtl/register_file_param_pkg.sv
// Shared constants and helpers for the parametrised integer register file.
package register_file_param_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;

  // Ceiling log2 as a constant function; sizes selects and the busy counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // A select addresses a real, writable register: nonzero and inside the array.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned reg_count);
    return (sel != REG_ZERO) && (sel < reg_count);
  endfunction

endpackage

// File: rtl/register_file_param_scoreboard.sv
// Busy scoreboard: one bit per register, set by reserve, cleared by write.
module register_scoreboard
  import register_file_param_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_enable_i,
  input  logic [ADDR_W-1:0]              write_select_i,
  input  logic                           reserve_enable_i,
  input  logic [ADDR_W-1:0]              reserve_select_i,
  input  logic [READ_PORTS*ADDR_W-1:0]   read_select_i,
  output logic [READ_PORTS-1:0]          busy_o,
  output logic [CNT_W-1:0]               busy_count_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_valid, rsv_valid;
  logic [ADDR_W-1:0]    look_sel;

  assign wr_valid  = write_enable_i   && sel_valid(32'(write_select_i), REG_COUNT);
  assign rsv_valid = reserve_enable_i && sel_valid(32'(reserve_select_i), REG_COUNT);

  // Reserve is applied after the write clear so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[write_select_i] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[reserve_select_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    busy_o   = '0;
    look_sel = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      look_sel = read_select_i[p*ADDR_W +: ADDR_W];
      if (sel_valid(32'(look_sel), REG_COUNT)) begin
        busy_o[p] = busy_q[look_sel];
        if ((BYPASS != 0) && wr_valid && (write_select_i == look_sel) &&
            !(rsv_valid && (reserve_select_i == look_sel))) begin
          busy_o[p] = 1'b0;
        end
      end
    end
  end

  assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_param.sv
// Parametrised integer register file with optional bypass, registered reads and busy scoreboard.
module register_file_param
  import register_file_param_pkg::*;
#(
  parameter int unsigned XLEN            = XLEN_DEFAULT,
  parameter int unsigned REG_COUNT       = 32,
  parameter int unsigned READ_PORTS      = 2,
  parameter int unsigned BYPASS          = 1,
  parameter int unsigned REGISTERED_READ = 0,
  localparam int unsigned ADDR_W         = clog2(REG_COUNT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [ADDR_W-1:0]            register_write_select,
  input  logic [XLEN-1:0]              register_data_write,
  input  logic [READ_PORTS*ADDR_W-1:0] read_select,
  output logic [READ_PORTS*XLEN-1:0]   read_data,
  input  logic                         reserve_enable,
  input  logic [ADDR_W-1:0]            reserve_select,
  output logic [READ_PORTS-1:0]        read_busy,
  output logic [ADDR_W:0]              busy_count
);

  logic [XLEN-1:0]            regs_q [REG_COUNT];
  logic                       wr_valid;
  logic [READ_PORTS*XLEN-1:0] rd_data_d;
  logic [READ_PORTS-1:0]      rd_busy_d;
  logic [ADDR_W-1:0]          rd_sel;

  assign wr_valid = write_enable && sel_valid(32'(register_write_select), REG_COUNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[register_write_select] <= register_data_write;
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_sel    = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_sel = read_select[p*ADDR_W +: ADDR_W];
      if (sel_valid(32'(rd_sel), REG_COUNT)) begin
        if ((BYPASS != 0) && wr_valid && (register_write_select == rd_sel)) begin
          rd_data_d[p*XLEN +: XLEN] = register_data_write;
        end else begin
          rd_data_d[p*XLEN +: XLEN] = regs_q[rd_sel];
        end
      end
    end
  end

  register_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .READ_PORTS (READ_PORTS),
    .BYPASS     (BYPASS),
    .ADDR_W     (ADDR_W),
    .CNT_W      (ADDR_W + 1)
  ) u_scoreboard (
    .clock            (clock),
    .reset            (reset),
    .write_enable_i   (write_enable),
    .write_select_i   (register_write_select),
    .reserve_enable_i (reserve_enable),
    .reserve_select_i (reserve_select),
    .read_select_i    (read_select),
    .busy_o           (rd_busy_d),
    .busy_count_o     (busy_count)
  );

  // Registered mode captures the same bypassed selection, so latency is uniform for data and busy.
  if (REGISTERED_READ != 0) begin : g_reg_read
    logic [READ_PORTS*XLEN-1:0] rd_data_q;
    logic [READ_PORTS-1:0]      rd_busy_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end

    assign read_data = rd_data_q;
    assign read_busy = rd_busy_q;
  end else begin : g_comb_read
    assign read_data = rd_data_d;
    assign read_busy = rd_busy_d;
  end

endmodule

// File: tb/tb_register_file_param.sv
// Checks three register file configurations against an array-based reference model.
module tb_register_file_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  rsel;
  logic [9:0]  rdsel;

  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  bz_a, bz_b, bz_c;
  logic [5:0]  cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  // cfg0: bypass, comb read; cfg1: no bypass, 24 regs; cfg2: bypass, registered read
  int unsigned cfg_rc [3] = '{32, 24, 32};
  int unsigned cfg_bp [3] = '{1, 0, 1};
  int unsigned cfg_rr [3] = '{0, 0, 1};

  logic [31:0] mreg  [3][32];
  bit          mbusy [3][32];
  logic [31:0] rr_data [3][2];
  bit          rr_busy [3][2];
  bit          model_ok = 0;

  always #5 clock = ~clock;

  register_file_param #(.REG_COUNT(32), .BYPASS(1), .REGISTERED_READ(0)) dut_a (
    .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
    .register_data_write(wdata), .read_select(rdsel), .read_data(rd_a),
    .reserve_enable(re), .reserve_select(rsel), .read_busy(bz_a), .busy_count(cnt_a));

  register_file_param #(.REG_COUNT(24), .BYPASS(0), .REGISTERED_READ(0)) dut_b (
    .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
    .register_data_write(wdata), .read_select(rdsel), .read_data(rd_b),
    .reserve_enable(re), .reserve_select(rsel), .read_busy(bz_b), .busy_count(cnt_b));

  register_file_param #(.REG_COUNT(32), .BYPASS(1), .REGISTERED_READ(1)) dut_c (
    .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
    .register_data_write(wdata), .read_select(rdsel), .read_data(rd_c),
    .reserve_enable(re), .reserve_select(rsel), .read_busy(bz_c), .busy_count(cnt_c));

  function automatic bit valid_sel(int k, int unsigned s);
    return (s != 0) && (s < cfg_rc[k]);
  endfunction

  function automatic int unsigned port_sel(int p);
    logic [9:0] v;
    v = rdsel;
    return 32'(v[p*5 +: 5]);
  endfunction

  // Value a read must show right now, from the architectural contents plus forwarding.
  function automatic logic [31:0] want_data(int k, int p);
    int unsigned s;
    s = port_sel(p);
    if (!valid_sel(k, s)) return 32'h0;
    if (cfg_bp[k] != 0 && we && 32'(wsel) == s) return wdata;
    return mreg[k][s];
  endfunction

  function automatic bit want_busy(int k, int p);
    int unsigned s;
    s = port_sel(p);
    if (!valid_sel(k, s)) return 1'b0;
    if (cfg_bp[k] != 0 && we && 32'(wsel) == s && !(re && 32'(rsel) == s)) return 1'b0;
    return mbusy[k][s];
  endfunction

  function automatic int want_count(int k);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(mbusy[k][i]);
    return n;
  endfunction

  function automatic logic [31:0] got_data(int k, int p);
    case (k)
      0: return rd_a[p*32 +: 32];
      1: return rd_b[p*32 +: 32];
      default: return rd_c[p*32 +: 32];
    endcase
  endfunction

  function automatic bit got_busy(int k, int p);
    case (k)
      0: return bz_a[p];
      1: return bz_b[p];
      default: return bz_c[p];
    endcase
  endfunction

  function automatic int got_count(int k);
    case (k)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  task automatic check(input string name, input int k, input int p,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cfg%0d port%0d got=%h want=%h t=%0t", name, k, p, got, want, $time);
    end
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        rr_data[k][p] = reset ? 32'h0 : want_data(k, p);
        rr_busy[k][p] = reset ? 1'b0 : want_busy(k, p);
      end
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          mreg[k][i]  = 32'h0;
          mbusy[k][i] = 1'b0;
        end
      end else begin
        if (we && valid_sel(k, 32'(wsel))) begin
          mreg[k][wsel]  = wdata;
          mbusy[k][wsel] = 1'b0;
        end
        if (re && valid_sel(k, 32'(rsel))) mbusy[k][rsel] = 1'b1;
      end
    end
    if (reset) model_ok = 1;
  end

  always @(negedge clock) begin
    if (model_ok && !reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (cfg_rr[k] != 0) begin
            check("rdata", k, p, got_data(k, p), rr_data[k][p]);
            check("rbusy", k, p, 32'(got_busy(k, p)), 32'(rr_busy[k][p]));
          end else begin
            check("rdata", k, p, got_data(k, p), want_data(k, p));
            check("rbusy", k, p, 32'(got_busy(k, p)), 32'(want_busy(k, p)));
          end
        end
        check("count", k, 0, 32'(got_count(k)), 32'(want_count(k)));
        check("count_bound", k, 0, 32'(got_count(k) <= int'(cfg_rc[k]) - 1), 32'h1);
      end
    end
  end

  task automatic apply(input logic rst, input logic w, input int ws, input logic [31:0] wd,
                       input logic r, input int rs, input int s0, input int s1);
    @(posedge clock);
    #1;
    reset = rst; we = w; wsel = 5'(ws); wdata = wd;
    re = r; rsel = 5'(rs); rdsel = {5'(s1), 5'(s0)};
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wsel = '0; wdata = '0; re = 1'b0; rsel = '0; rdsel = '0;
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) apply(0, 0, 0, 0, 0, 0, i, 31 - i);
    settle();
    check("lit_reset_count", 0, 0, 32'(cnt_a), 32'h0);

    apply(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    settle();
    check("lit_bypass_r5", 0, 0, rd_a[31:0], 32'hDEADBEEF);
    check("lit_nobypass_r5", 1, 0, rd_b[31:0], 32'h0);
    apply(0, 1, 0, 32'h12345678, 0, 0, 5, 0);
    apply(0, 0, 0, 0, 0, 0, 5, 0);
    settle();
    check("lit_r5", 0, 0, rd_a[31:0], 32'hDEADBEEF);
    check("lit_r0", 0, 1, rd_a[63:32], 32'h0);
    check("lit_reg_r5", 2, 0, rd_c[31:0], 32'hDEADBEEF);

    apply(0, 1, 7, 32'h11, 0, 0, 0, 0);
    apply(0, 1, 7, 32'hCAFEF00D, 0, 0, 0, 7);
    settle();
    check("lit_bypass_r7", 0, 1, rd_a[63:32], 32'hCAFEF00D);
    check("lit_nobypass_r7", 1, 1, rd_b[63:32], 32'h11);

    apply(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    check("lit_reg_lat0", 2, 0, rd_c[31:0], 32'h0);
    apply(0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    check("lit_reg_lat1", 2, 0, rd_c[31:0], 32'hA5A5A5A5);
    apply(0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    check("lit_reg_hold", 2, 0, rd_c[31:0], 32'hA5A5A5A5);

    apply(0, 0, 0, 0, 1, 9, 9, 0);
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    settle();
    check("lit_busy9", 0, 0, 32'(bz_a[0]), 32'h1);
    check("lit_count1", 0, 0, 32'(cnt_a), 32'h1);
    apply(0, 1, 9, 32'h99, 1, 9, 9, 0);
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    settle();
    check("lit_busy9_both", 0, 0, 32'(bz_a[0]), 32'h1);
    check("lit_count1_both", 0, 0, 32'(cnt_a), 32'h1);
    apply(0, 1, 9, 32'h9A, 0, 0, 9, 0);
    settle();
    check("lit_busy9_mask", 0, 0, 32'(bz_a[0]), 32'h0);
    apply(0, 0, 0, 0, 1, 0, 9, 0);
    apply(0, 0, 0, 0, 0, 0, 9, 0);
    settle();
    check("lit_count0", 0, 0, 32'(cnt_a), 32'h0);

    apply(0, 1, 25, 32'h2525, 1, 26, 25, 26);
    apply(0, 0, 0, 0, 0, 0, 25, 26);
    settle();
    check("lit_oor_data", 1, 0, rd_b[31:0], 32'h0);
    check("lit_oor_count", 1, 0, 32'(cnt_b), 32'h0);
    check("lit_inr_data", 0, 0, rd_a[31:0], 32'h2525);

    apply(0, 0, 0, 0, 1, 4, 0, 0);
    apply(0, 0, 0, 0, 1, 6, 0, 0);
    apply(0, 1, 4, 32'h55, 0, 0, 4, 6);
    apply(1, 1, 6, 32'h77, 0, 0, 4, 6);
    apply(0, 0, 0, 0, 0, 0, 4, 6);
    settle();
    check("lit_rst_r4", 0, 0, rd_a[31:0], 32'h0);
    check("lit_rst_r6", 0, 1, rd_a[63:32], 32'h0);
    check("lit_rst_count", 0, 0, 32'(cnt_a), 32'h0);

    for (int n = 0; n < 60; n++) begin
      apply(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
